barret_for_2969: RTL and testbench

- Pipelined Barrett modular reducer: computes r = a mod 2969 for any 23-bit unsigned input a.
- Sits behind the 2969-field multiplier in the Galois datapath and folds raw products or sums back into the canonical residue range [0, 2968].
- Fully pipelined, one result per clock, fixed latency.

---
 rtl/barret_2969_pkg.sv | 11 +
 rtl/barret_for_2969_if.sv | 18 +
 rtl/barret_2969_csub.sv | 17 +
 rtl/barret_for_2969.sv | 63 ++++++
 tb/tb_barret_for_2969.sv | 107 ++++++++++
 5 files changed

// File: rtl/barret_2969_pkg.sv
// barret_2969_pkg: shared constants and residue type for the mod-2969 Barrett reducer
package barret_2969_pkg;
   localparam int unsigned P      = 2969;
   localparam int unsigned IN_W   = 23;
   localparam int unsigned OUT_W  = 12;
   localparam int unsigned K      = 24;
   localparam int unsigned M      = 5650;
   localparam int unsigned PROD_W = 36;
   localparam int unsigned T_W    = 14;
   typedef logic [OUT_W-1:0] residue_t;
endpackage

// File: rtl/barret_for_2969_if.sv
// barret_for_2969_if: sample-in / residue-out bus of the mod-2969 reducer
// master drives in_valid/din_a and receives out_valid/dout_r (and corr_cnt when
// BARRET_2969_CORR_CNT_EN is defined); slave is the reducer side.
interface barret_for_2969_if;
   import barret_2969_pkg::*;
   logic            in_valid;
   logic [IN_W-1:0] din_a;
   logic            out_valid;
   residue_t        dout_r;
`ifdef BARRET_2969_CORR_CNT_EN
   logic [1:0]      corr_cnt;
   modport master(output in_valid, din_a, input out_valid, dout_r, corr_cnt);
   modport slave(input in_valid, din_a, output out_valid, dout_r, corr_cnt);
`else
   modport master(output in_valid, din_a, input out_valid, dout_r);
   modport slave(input in_valid, din_a, output out_valid, dout_r);
`endif
endinterface

// File: rtl/barret_2969_csub.sv
// barret_2969_csub: combinational conditional subtract of P with a subtracted flag
// x_i: value to reduce, y_o: x_i or x_i-P (truncated to W_OUT), sub_o: 1 when P was subtracted
module barret_2969_csub
   import barret_2969_pkg::*;
#(
   parameter int unsigned W_IN  = T_W,
   parameter int unsigned W_OUT = T_W
) (
   input  logic [W_IN-1:0]  x_i,
   output logic [W_OUT-1:0] y_o,
   output logic             sub_o
);
   always_comb begin
      sub_o = x_i >= W_IN'(P);
      y_o   = W_OUT'(sub_o ? x_i - W_IN'(P) : x_i);
   end
endmodule

// File: rtl/barret_for_2969.sv
// barret_for_2969: 3-cycle pipelined Barrett reducer, dout_r = din_a mod 2969
// Ports: clk, rst_n (async active-low), bus (slave: in_valid, din_a -> out_valid, dout_r).
// Optional macro BARRET_2969_CORR_CNT_EN adds bus.corr_cnt, the number of
// final-stage subtractions of P, aligned with dout_r.
module barret_for_2969
   import barret_2969_pkg::*;
(
   input logic               clk,
   input logic               rst_n,
   barret_for_2969_if.slave  bus
);
   logic            v1_q, v2_q, v3_q, vo_q;
   logic [IN_W-1:0] a1_q;
   logic [T_W-1:0]  a2_q, t3_q, t3_d, y1;
   residue_t        q2_q, q2_d, r_q, r_d, y2;
   logic            s1, s2;
   barret_2969_csub #(.W_IN(T_W), .W_OUT(T_W)) u_sub1 (.x_i(t3_q), .y_o(y1), .sub_o(s1));
   barret_2969_csub #(.W_IN(T_W), .W_OUT(OUT_W)) u_sub2 (.x_i(y1), .y_o(y2), .sub_o(s2));
   // t only needs its low T_W bits: the true value is below 3P, so the
   // subtraction can be done modulo 2^T_W on the low bits of a and q*P.
   always_comb begin
      q2_d = OUT_W'((PROD_W'(a1_q) * PROD_W'(M)) >> K);
      t3_d = a2_q - T_W'(q2_q * P);
      r_d  = v3_q ? y2 : r_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         vo_q <= 1'b0;
         a1_q <= '0;
         a2_q <= '0;
         q2_q <= '0;
         t3_q <= '0;
         r_q  <= '0;
      end else begin
         v1_q <= bus.in_valid;
         v2_q <= v1_q;
         v3_q <= v2_q;
         vo_q <= v3_q;
         a1_q <= bus.din_a;
         a2_q <= T_W'(a1_q);
         q2_q <= q2_d;
         t3_q <= t3_d;
         r_q  <= r_d;
      end
   end
   assign bus.out_valid = vo_q;
   assign bus.dout_r    = r_q;
`ifdef BARRET_2969_CORR_CNT_EN
   logic [1:0] cnt_q, cnt_d;
   always_comb cnt_d = v3_q ? {1'b0, s1} + {1'b0, s2} : cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign bus.corr_cnt = cnt_q;
`else
   logic unused_sub;
   assign unused_sub = s1 ^ s2;
`endif
endmodule

// File: tb/tb_barret_for_2969.sv
// tb_barret_for_2969: self-checking bench for the mod-2969 Barrett reducer
module tb_barret_for_2969;
   import barret_2969_pkg::*;
   typedef struct {
      int unsigned a;
      int unsigned r;
      int unsigned c;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          pass = 0;
   int          total = 0;
   bit          hv[4];
   int unsigned ha[4];
   int unsigned exp_r;
   vec_t        tbl[8];
   always #5 clk = ~clk;
   barret_for_2969_if bus();
   barret_for_2969 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act == exp) pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask
   task automatic clear_model();
      for (int i = 0; i < 4; i++) begin
         hv[i] = 1'b0;
         ha[i] = 0;
      end
      exp_r = 0;
   endtask
   // Drive one cycle, then compare against the sample taken three edges earlier;
   // dout_r is expected to hold its last value across bubbles.
   task automatic step(input bit v, input int unsigned a);
      bus.in_valid = v;
      bus.din_a    = a[22:0];
      @(posedge clk);
      #1;
      for (int i = 3; i > 0; i--) begin
         hv[i] = hv[i-1];
         ha[i] = ha[i-1];
      end
      hv[0] = v;
      ha[0] = a;
      if (hv[3]) exp_r = ha[3] % 2969;
      chk("out_valid", 32'(bus.out_valid), 32'(hv[3]));
      chk("dout_r", 32'(bus.dout_r), exp_r);
   endtask
   initial begin
      tbl[0] = '{0, 0, 0};
      tbl[1] = '{2968, 2968, 0};
      tbl[2] = '{2969, 0, 1};
      tbl[3] = '{5937, 2968, 0};
      tbl[4] = '{5938, 0, 1};
      tbl[5] = '{8388607, 1182, 1};
      tbl[6] = '{12345, 469, 0};
      tbl[7] = '{1234, 1234, 0};
      bus.in_valid = 1'b0;
      bus.din_a    = '0;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      chk("reset out_valid", 32'(bus.out_valid), 0);
      chk("reset dout_r", 32'(bus.dout_r), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1234);
      step(1'b0, 0);
      step(1'b0, 0);
      chk("release early valid", 32'(bus.out_valid), 0);
      step(1'b0, 0);
      chk("release valid", 32'(bus.out_valid), 1);
      chk("release data", 32'(bus.dout_r), 1234);
      for (int i = 0; i < 2969; i++) step(1'b1, i);
      for (int k = 0; k < 8; k++) begin
         step(1'b1, tbl[k].a);
         repeat (3) step(1'b0, 0);
         chk("table residue", 32'(bus.dout_r), tbl[k].r);
`ifdef BARRET_2969_CORR_CNT_EN
         chk("table corr_cnt", 32'(bus.corr_cnt), tbl[k].c);
`endif
      end
      repeat (4000) begin
         step(1'b1, $urandom_range(0, 8388607));
         chk("range", 32'(bus.dout_r < 12'd2969), 1);
      end
      for (int i = 0; i < 40; i++) step(i % 2 == 0, $urandom_range(0, 8388607));
      repeat (3) step(1'b0, 0);
      step(1'b1, 100);
      step(1'b1, 200);
      step(1'b1, 300);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async out_valid", 32'(bus.out_valid), 0);
      chk("async dout_r", 32'(bus.dout_r), 0);
      clear_model();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) step(1'b0, 0);
      step(1'b1, 777);
      repeat (3) step(1'b0, 0);
      chk("post reset data", 32'(bus.dout_r), 777);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
